// File: rtl/mealy_seq_detector_if.sv
// Signal bundle between a serial-stream source and mealy_seq_detector.
// Latency: none, this is wiring only.
// Backpressure: none. The source qualifies each bit with enable and the detector always accepts it.
//
// Ports (master = stream source / bench, slave = detector):
//   clear        sync clear of detector state and match count
//   pat_load     sync load of pat_in into the pattern register
//   pat_in       new pattern, MSB is the first bit received
//   enable       in_bit is valid this cycle
//   in_bit       serial data bit
//   out          Mealy match strobe, combinational from in_bit
//   match_count  saturating number of matches
//   state        current matched-prefix length (debug)
//   pat          current pattern register contents (debug)
interface mealy_seq_detector_if #(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
);
   localparam int ST_W = $clog2(PAT_LEN);

   logic               clear;
   logic               pat_load;
   logic [PAT_LEN-1:0] pat_in;
   logic               enable;
   logic               in_bit;

   logic               out;
   logic [CNT_W-1:0]   match_count;
   logic [ST_W-1:0]    state;
   logic [PAT_LEN-1:0] pat;

   modport master (
      output clear, pat_load, pat_in, enable, in_bit,
      input  out, match_count, state, pat
   );

   modport slave (
      input  clear, pat_load, pat_in, enable, in_bit,
      output out, match_count, state, pat
   );
endinterface

// File: rtl/mealy_seq_detector.sv
// Mealy serial-pattern detector with a runtime-loadable pattern and a saturating match counter.
// Latency: out is combinational, asserted in the same cycle as the last pattern bit.
// Backpressure: none. One bit is consumed on every enabled cycle and idle cycles hold all state.
//
// Ports:
//   clock_i   rising-edge clock
//   reset_ni  asynchronous active-low reset (pattern <= PATTERN, state <= 0, count <= 0)
//   det_if    slave side of mealy_seq_detector_if (control, serial data, match strobe, count, debug)
//
// Parameters:
//   PAT_LEN  pattern length in bits, 2..16
//   PATTERN  reset pattern, MSB is the first bit received
//   OVERLAP  1: matches may overlap, 0: detection restarts from empty after a match
//   CNT_W    width of the match counter
module mealy_seq_detector #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1110,
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8
) (
   input  logic                 clock_i,
   input  logic                 reset_ni,
   mealy_seq_detector_if.slave  det_if
);

   localparam int               ST_W    = $clog2(PAT_LEN);
   localparam logic [ST_W-1:0]  LAST_ST = ST_W'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Operation selected for this cycle; clear beats pat_load beats enable.
   typedef enum logic [1:0] {
      OP_HOLD,
      OP_CLEAR,
      OP_LOAD,
      OP_SHIFT
   } op_e;

   op_e                op;

   logic [PAT_LEN-1:0] pat_q, pat_d;
   logic [ST_W-1:0]    state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Pattern in reception order: pbit[j] is the j-th bit received.
   logic [PAT_LEN-1:0] pbit;

   // fb_tbl[k][b]: new prefix length after receiving bit b in state k, ignoring the
   // non-overlap restart. Capped at PAT_LEN-1, so for k = PAT_LEN-1 with the matching
   // bit it yields the longest proper prefix that is also a suffix of the pattern.
   logic [ST_W-1:0]    fb_tbl [PAT_LEN][2];
   logic               fb_ok;

   logic               hit;

   always_comb begin
      pbit = '0;
      for (int j = 0; j < PAT_LEN; j++) begin
         pbit[j] = pat_q[PAT_LEN-1-j];
      end
   end

   // In state k the last k received bits equal pbit[0..k-1]. Appending b gives the
   // string pbit[0..k-1],b. A candidate length l fits when b == pbit[l-1] and the
   // preceding l-1 received bits, pbit[k+1-l .. k-1], equal pbit[0 .. l-2].
   // The longest l that fits wins, so the loop keeps overwriting as l grows.
   always_comb begin
      fb_ok = 1'b0;
      for (int k = 0; k < PAT_LEN; k++) begin
         for (int b = 0; b < 2; b++) begin
            fb_tbl[k][b] = '0;
            for (int l = 1; (l <= k + 1) && (l < PAT_LEN); l++) begin
               fb_ok = (pbit[l-1] == b[0]);
               for (int t = 0; t < l - 1; t++) begin
                  if (pbit[k+1-l+t] != pbit[t]) begin
                     fb_ok = 1'b0;
                  end
               end
               if (fb_ok) begin
                  fb_tbl[k][b] = ST_W'(l);
               end
            end
         end
      end
   end

   always_comb begin
      op      = OP_HOLD;
      hit     = 1'b0;
      pat_d   = pat_q;
      state_d = state_q;
      cnt_d   = cnt_q;

      if (det_if.clear) begin
         op = OP_CLEAR;
      end else if (det_if.pat_load) begin
         op = OP_LOAD;
      end else if (det_if.enable) begin
         op = OP_SHIFT;
      end

      case (op)
         OP_CLEAR: begin
            state_d = '0;
            cnt_d   = '0;
         end
         OP_LOAD: begin
            // The enabled bit of this cycle, if any, is dropped on purpose.
            pat_d   = det_if.pat_in;
            state_d = '0;
         end
         OP_SHIFT: begin
            // pat_q[0] is the last bit of the pattern to be received.
            hit = (state_q == LAST_ST) && (det_if.in_bit == pat_q[0]);
            if (hit) begin
               state_d = OVERLAP ? fb_tbl[state_q][det_if.in_bit] : '0;
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = fb_tbl[state_q][det_if.in_bit];
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         pat_q   <= PATTERN;
         state_q <= '0;
         cnt_q   <= '0;
      end else begin
         pat_q   <= pat_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Gated with reset so the strobe is low for the whole time reset is held.
   assign det_if.out         = hit & reset_ni;
   assign det_if.match_count = cnt_q;
   assign det_if.state       = state_q;
   assign det_if.pat         = pat_q;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Bench for mealy_seq_detector: three instances share one stimulus.
// u_ovl: 1110 overlapping, u_novl: 1110 non-overlapping, u_sat: 1111 overlapping with a 2-bit counter.
module tb_mealy_seq_detector;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       c_clear, c_ld, c_en, c_in;
   logic [3:0] c_pat;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_c0 = 0;
   int exp_c1 = 0;

   always #5 clk = ~clk;

   mealy_seq_detector_if #(.PAT_LEN(4), .CNT_W(8)) if0 ();
   mealy_seq_detector_if #(.PAT_LEN(4), .CNT_W(8)) if1 ();
   mealy_seq_detector_if #(.PAT_LEN(4), .CNT_W(2)) if2 ();

   assign if0.clear = c_clear;  assign if0.pat_load = c_ld;  assign if0.pat_in = c_pat;
   assign if0.enable = c_en;    assign if0.in_bit = c_in;
   assign if1.clear = c_clear;  assign if1.pat_load = c_ld;  assign if1.pat_in = c_pat;
   assign if1.enable = c_en;    assign if1.in_bit = c_in;
   assign if2.clear = c_clear;  assign if2.pat_load = c_ld;  assign if2.pat_in = c_pat;
   assign if2.enable = c_en;    assign if2.in_bit = c_in;

   mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1110), .OVERLAP(1'b1), .CNT_W(8)) u_ovl (
      .clock_i(clk), .reset_ni(rst_n), .det_if(if0.slave));
   mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1110), .OVERLAP(1'b0), .CNT_W(8)) u_novl (
      .clock_i(clk), .reset_ni(rst_n), .det_if(if1.slave));
   mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
      .clock_i(clk), .reset_ni(rst_n), .det_if(if2.slave));

   typedef struct {
      logic [3:0] pat;
      logic       in_bit;
      logic       e0;
      logic       e1;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic clr, input logic ld, input logic [3:0] pat,
                        input logic en, input logic b);
      @(negedge clk);
      c_clear = clr; c_ld = ld; c_pat = pat; c_en = en; c_in = b;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One enabled bit: check both 1110-class strobes, then the running counts.
   task automatic send(input logic b, input logic e0, input logic e1, input string tag);
      drive(1'b0, 1'b0, 4'b0000, 1'b1, b);
      chk({tag, "_out0"}, 32'(if0.out), 32'(e0));
      chk({tag, "_out1"}, 32'(if1.out), 32'(e1));
      tick();
      if (e0) exp_c0++;
      if (e1) exp_c1++;
      chk({tag, "_cnt0"}, 32'(if0.match_count), exp_c0);
      chk({tag, "_cnt1"}, 32'(if1.match_count), exp_c1);
   endtask

   task automatic clear_all();
      drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
      tick();
      exp_c0 = 0;
      exp_c1 = 0;
      chk("clr_cnt0", 32'(if0.match_count), 0);
      chk("clr_state0", 32'(if0.state), 0);
   endtask

   task automatic load(input logic [3:0] p);
      drive(1'b0, 1'b1, p, 1'b0, 1'b0);
      tick();
      chk("load_pat0", 32'(if0.pat), 32'(p));
      chk("load_state0", 32'(if0.state), 0);
   endtask

   // Reference: longest L < 4, L <= len, with the newest L bits equal to the pattern's first L bits.
   function automatic int model_state(input logic [31:0] w, input int len, input logic [3:0] p);
      int   best;
      logic ok;
      best = 0;
      for (int l = 1; l < 4; l++) begin
         ok = (l <= len);
         for (int t = 0; t < l; t++) begin
            if (w[l-1-t] !== p[3-t]) ok = 1'b0;
         end
         if (ok) best = l;
      end
      return best;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tv [32];
      logic [15:0] stream;
      logic [15:0] m_t2, m_t3o, m_t3n;
      int          sat_tab [10];
      logic [3:0]  rpat [4];
      logic [31:0] w0, w1;
      int          l0, l1;
      logic        en, b, m0, m1;

      stream = 16'h5772;   // 0101_0111_0111_0010, sent LSB first
      m_t2   = 16'h0880;   // 1110: matches on bits 7 and 11
      m_t3o  = 16'hA000;   // 1010 overlapping: bits 13 and 15
      m_t3n  = 16'h2000;   // 1010 non-overlapping: bit 13
      for (int i = 0; i < 16; i++) begin
         tv[i]      = '{4'b1110, stream[i], m_t2[i], m_t2[i]};
         tv[16 + i] = '{4'b1010, stream[i], m_t3o[i], m_t3n[i]};
      end
      sat_tab = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 3};
      rpat    = '{4'b1010, 4'b1001, 4'b0110, 4'b1100};

      // Reset state
      rst_n = 1'b0;
      c_clear = 1'b0; c_ld = 1'b0; c_pat = 4'b0000; c_en = 1'b0; c_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state0", 32'(if0.state), 0);
      chk("rst_cnt0", 32'(if0.match_count), 0);
      chk("rst_pat0", 32'(if0.pat), 32'h0000000E);
      chk("rst_pat2", 32'(if2.pat), 32'h0000000F);
      chk("rst_out0", 32'(if0.out), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // T1: reset mid-stream loses the loaded pattern, partial match and count
      load(4'b0110);
      send(1'b0, 1'b0, 1'b0, "t1a"); send(1'b1, 1'b0, 1'b0, "t1a");
      send(1'b1, 1'b0, 1'b0, "t1a"); send(1'b0, 1'b1, 1'b1, "t1a");
      send(1'b0, 1'b0, 1'b0, "t1b"); send(1'b1, 1'b0, 1'b0, "t1b");
      send(1'b1, 1'b0, 1'b0, "t1b");
      chk("t1_pre_state0", 32'(if0.state), 3);
      @(negedge clk);
      rst_n = 1'b0; c_clear = 1'b0; c_ld = 1'b0; c_en = 1'b1; c_in = 1'b1;
      #1;
      chk("t1_state0", 32'(if0.state), 0);
      chk("t1_cnt0", 32'(if0.match_count), 0);
      chk("t1_out0", 32'(if0.out), 0);
      chk("t1_pat0", 32'(if0.pat), 32'h0000000E);
      c_in = 1'b0;   // the bit that would have completed 0110
      #1;
      chk("t1_out0_in0", 32'(if0.out), 0);
      tick();
      chk("t1_hold_state0", 32'(if0.state), 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_c0 = 0; exp_c1 = 0;
      send(1'b1, 1'b0, 1'b0, "t1c"); send(1'b1, 1'b0, 1'b0, "t1c");
      send(1'b1, 1'b0, 1'b0, "t1c"); send(1'b0, 1'b1, 1'b1, "t1c");

      // T2 (entries 0..15) and T3 (entries 16..31) from the vector table
      for (int i = 0; i < 32; i++) begin
         if (i % 16 == 0) begin
            clear_all();
            load(tv[i].pat);
         end
         send(tv[i].in_bit, tv[i].e0, tv[i].e1, (i < 16) ? "t2" : "t3");
         if (i == 15) begin
            chk("t2_cnt0", 32'(if0.match_count), 2);
            chk("t2_cnt1", 32'(if1.match_count), 2);
         end
         if (i == 31) begin
            chk("t3_cnt_ovl", 32'(if0.match_count), 2);
            chk("t3_cnt_novl", 32'(if1.match_count), 1);
         end
      end

      // T4: T2 stream with three idle cycles after every bit, random data while idle
      clear_all();
      load(4'b1110);
      for (int i = 0; i < 16; i++) begin
         send(stream[i], m_t2[i], m_t2[i], "t4");
         for (int g = 0; g < 3; g++) begin
            drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'($urandom_range(0, 1)));
            chk("t4_gap_out0", 32'(if0.out), 0);
            chk("t4_gap_out1", 32'(if1.out), 0);
            tick();
            chk("t4_gap_cnt0", 32'(if0.match_count), exp_c0);
         end
      end
      chk("t4_cnt0", 32'(if0.match_count), 2);

      // T5: all-ones pattern, saturation of the 2-bit counter, restart in non-overlap mode
      clear_all();
      load(4'b1111);
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
         chk("t5_out2", 32'(if2.out), 32'(i >= 3));
         chk("t5_out0", 32'(if0.out), 32'(i >= 3));
         chk("t5_out1", 32'(if1.out), 32'((i == 3) || (i == 7)));
         tick();
         chk("t5_cnt2", 32'(if2.match_count), sat_tab[i]);
      end
      chk("t5_cnt0", 32'(if0.match_count), 7);
      chk("t5_cnt1", 32'(if1.match_count), 2);

      // T6: clear + pat_load on a matching bit, then pat_load alone on a matching bit
      drive(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
      chk("t6a_out0", 32'(if0.out), 0);
      chk("t6a_out2", 32'(if2.out), 0);
      tick();
      chk("t6a_cnt0", 32'(if0.match_count), 0);
      chk("t6a_cnt2", 32'(if2.match_count), 0);
      chk("t6a_pat0", 32'(if0.pat), 32'h0000000F);
      chk("t6a_state0", 32'(if0.state), 0);
      exp_c0 = 0; exp_c1 = 0;
      send(1'b1, 1'b0, 1'b0, "t6b"); send(1'b1, 1'b0, 1'b0, "t6b");
      send(1'b1, 1'b0, 1'b0, "t6b"); send(1'b1, 1'b1, 1'b1, "t6b");
      drive(1'b0, 1'b1, 4'b0111, 1'b1, 1'b1);
      chk("t6c_out0", 32'(if0.out), 0);
      tick();
      chk("t6c_cnt0", 32'(if0.match_count), 1);
      chk("t6c_state0", 32'(if0.state), 0);
      chk("t6c_pat0", 32'(if0.pat), 32'h00000007);
      send(1'b0, 1'b0, 1'b0, "t6d"); send(1'b1, 1'b0, 1'b0, "t6d");
      send(1'b1, 1'b0, 1'b0, "t6d"); send(1'b1, 1'b1, 1'b1, "t6d");

      // Random streams against the reference model, 1000 bits per mode
      for (int p = 0; p < 4; p++) begin
         clear_all();
         load(rpat[p]);
         w0 = '0; w1 = '0; l0 = 0; l1 = 0;
         for (int n = 0; n < 250; n++) begin
            en = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom_range(0, 1));
            m0 = 1'b0;
            m1 = 1'b0;
            if (en) begin
               w0 = {w0[30:0], b};
               if (l0 < 31) l0++;
               m0 = (l0 >= 4) && (w0[3:0] == rpat[p]);
               w1 = {w1[30:0], b};
               if (l1 < 31) l1++;
               m1 = (l1 >= 4) && (w1[3:0] == rpat[p]);
               if (m1) l1 = 0;
            end
            drive(1'b0, 1'b0, 4'b0000, en, b);
            chk("rnd_out0", 32'(if0.out), 32'(m0));
            chk("rnd_out1", 32'(if1.out), 32'(m1));
            tick();
            if (m0) exp_c0++;
            if (m1) exp_c1++;
            chk("rnd_state0", 32'(if0.state), model_state(w0, l0, rpat[p]));
            chk("rnd_state1", 32'(if1.state), model_state(w1, l1, rpat[p]));
         end
         chk("rnd_cnt0", 32'(if0.match_count), exp_c0);
         chk("rnd_cnt1", 32'(if1.match_count), exp_c1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
